// File: rtl/mux16_word_arbiter.sv
// mux16_word_arbiter: two-requester arbiter for the shared 16-bit 2:1 word mux,
// feeding a single-entry valid/ready output register.
// Optional feature macro: MUX16_ARB_RR_EN (defined = round-robin tie-break,
// undefined = fixed priority, requester 0 wins ties).
module mux16_word_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req0_Valid,
  input  logic [15:0]      Req0_Data,
  output logic             Req0_Ready,
  input  logic             Req1_Valid,
  input  logic [15:0]      Req1_Data,
  output logic             Req1_Ready,
  output logic             Mux_Sel,
  input  logic [15:0]      Mux_Result,
  output logic             Out_Valid,
  output logic [15:0]      Out_Data,
  input  logic             Out_Ready,
  output logic             Out_Src,
  output logic [CNT_W-1:0] Word_Count
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                src_q, src_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                grant0, grant1;
  logic                space;
  logic                accept;

  // Request data reaches the capture register only through the external mux.
  logic [DATA_W-1:0]   unused_req_data;
  assign unused_req_data = Req0_Data ^ Req1_Data;

`ifdef MUX16_ARB_RR_EN
  logic                last_q, last_d;

  // Round-robin grant: a tie goes to the requester not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    grant0 = Req0_Valid && (!Req1_Valid || last_q);
    grant1 = Req1_Valid && (!Req0_Valid || !last_q);
  end
`else
  // Fixed-priority grant: requester 0 always wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    grant0 = Req0_Valid;
    grant1 = Req1_Valid && !Req0_Valid;
  end
`endif

  // Space exists when the output register is empty or is being drained now.
  assign space      = (state_q == ST_EMPTY) || Out_Ready;
  assign Req0_Ready = grant0 && space;
  assign Req1_Ready = grant1 && space;
  assign accept     = Req0_Ready || Req1_Ready;
  // Idle select parks on requester 0.
  assign Mux_Sel    = !grant1;

  // Next-state and datapath update for the output stage.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
`ifdef MUX16_ARB_RR_EN
    last_d  = last_q;
`endif
    if (accept) begin
      state_d = ST_FULL;
      data_d  = Mux_Result;
      src_d   = grant1;
      cnt_d   = cnt_q + CNT_W'(1);
`ifdef MUX16_ARB_RR_EN
      last_d  = grant1;
`endif
    end else if ((state_q == ST_FULL) && Out_Ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State and output registers; reset discards any held word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MUX16_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
`ifdef MUX16_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign Out_Valid  = (state_q == ST_FULL);
  assign Out_Data   = data_q;
  assign Out_Src    = src_q;
  assign Word_Count = cnt_q;

endmodule

// File: tb/tb_mux16_word_arbiter.sv
// Self-checking bench for mux16_word_arbiter with a reference grant model
// and a scoreboard of expected captured words.
module tb_mux16_word_arbiter;

  localparam int unsigned CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Req0_Valid, Req1_Valid;
  logic [15:0]      Req0_Data, Req1_Data;
  logic             Req0_Ready, Req1_Ready;
  logic             Mux_Sel;
  logic [15:0]      Mux_Result;
  logic             Out_Valid;
  logic [15:0]      Out_Data;
  logic             Out_Ready;
  logic             Out_Src;
  logic [CNT_W-1:0] Word_Count;

  typedef struct {
    logic        src;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic        m_full;
  logic        m_last;
  logic [15:0] m_data;
  logic        m_src;
  int          m_count;

  always #5 CLK = ~CLK;

  // External 16-bit 2:1 mux: select 1 passes requester 0.
  assign Mux_Result = Mux_Sel ? Req0_Data : Req1_Data;

  mux16_word_arbiter #(.CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Req0_Valid (Req0_Valid),
    .Req0_Data  (Req0_Data),
    .Req0_Ready (Req0_Ready),
    .Req1_Valid (Req1_Valid),
    .Req1_Data  (Req1_Data),
    .Req1_Ready (Req1_Ready),
    .Mux_Sel    (Mux_Sel),
    .Mux_Result (Mux_Result),
    .Out_Valid  (Out_Valid),
    .Out_Data   (Out_Data),
    .Out_Ready  (Out_Ready),
    .Out_Src    (Out_Src),
    .Word_Count (Word_Count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full  = 1'b0;
    m_last  = 1'b1;
    m_data  = 16'h0000;
    m_src   = 1'b0;
    m_count = 0;
    sb.delete();
  endtask

  // One cycle: drive at negedge, check combinational grant, then check registers.
  task automatic step(input logic v0, input logic [15:0] d0,
                      input logic v1, input logic [15:0] d1, input logic ordy);
    logic sp, g0, g1, acc;
    exp_t e;
    @(negedge CLK);
    Req0_Valid = v0;
    Req0_Data  = d0;
    Req1_Valid = v1;
    Req1_Data  = d1;
    Out_Ready  = ordy;
    #1;
    sp = !m_full || ordy;
`ifdef MUX16_ARB_RR_EN
    g0 = v0 && (!v1 || m_last);
    g1 = v1 && (!v0 || !m_last);
`else
    g0 = v0;
    g1 = v1 && !v0;
`endif
    acc = (g0 || g1) && sp;
    check("req0_ready", 32'(Req0_Ready), 32'(g0 && sp));
    check("req1_ready", 32'(Req1_Ready), 32'(g1 && sp));
    check("mux_sel", 32'(Mux_Sel), 32'(!g1));
    if (acc) begin
      e.src  = g1;
      e.data = g1 ? d1 : d0;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    if (acc) begin
      m_full  = 1'b1;
      m_count = m_count + 1;
      m_last  = g1;
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        m_data = e.data;
        m_src  = e.src;
      end
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    check("out_valid", 32'(Out_Valid), 32'(m_full));
    check("out_data", 32'(Out_Data), 32'(m_data));
    check("out_src", 32'(Out_Src), 32'(m_src));
    check("word_count", 32'(Word_Count), 32'(m_count) & ((32'd1 << CNT_W) - 32'd1));
  endtask

  initial begin
    RST        = 1'b1;
    Req0_Valid = 1'b0;
    Req1_Valid = 1'b0;
    Req0_Data  = 16'h0000;
    Req1_Data  = 16'h0000;
    Out_Ready  = 1'b0;
    model_reset();

    // Reset values
    #12;
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_out_data", 32'(Out_Data), 32'h0);
    check("rst_out_src", 32'(Out_Src), 32'd0);
    check("rst_word_count", 32'(Word_Count), 32'd0);
    check("rst_mux_sel", 32'(Mux_Sel), 32'd1);
    check("rst_req0_ready", 32'(Req0_Ready), 32'd0);
    check("rst_req1_ready", 32'(Req1_Ready), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Asynchronous reset while holding BEEF
    step(1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    Req0_Valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check("async_rst_out_valid", 32'(Out_Valid), 32'd0);
    check("async_rst_out_data", 32'(Out_Data), 32'h0);
    check("async_rst_word_count", 32'(Word_Count), 32'd0);
    check("async_rst_mux_sel", 32'(Mux_Sel), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    // Single requester 1
    step(1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

    // Contention for four cycles
    for (int i = 0; i < 4; i++) step(1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);

    // Backpressure: hold while full, then same-edge replacement
    for (int i = 0; i < 3; i++) step(1'b1, 16'hC0DE, 1'b1, 16'h7777, 1'b0);
    step(1'b1, 16'hC0DE, 1'b1, 16'h7777, 1'b1);
    step(1'b1, 16'hC0DE, 1'b1, 16'h7777, 1'b1);

    // Drain: one accept then idle
    step(1'b0, 16'h0000, 1'b1, 16'h4242, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

    // Counter wrap from a fresh reset
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 256; i++) step(1'b1, 16'(i), 1'b0, 16'h0000, 1'b1);
    check("wrap_to_zero", 32'(Word_Count), 32'd0);
    step(1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    check("wrap_then_one", 32'(Word_Count), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_word_arbiter.md
# mux16_word_arbiter

Two-requester arbiter and sequencer for the shared 16-bit 2:1 word multiplexer in the AES datapath. The arbiter picks one of two 16-bit word sources each cycle and drives the select of the external 16-bit mux. It takes the mux result back and registers it into a single-entry output stage with valid/ready handshakes. It sits between the key-schedule and state-update word producers and the shared downstream word consumer.

## Interface
- CNT_W, default 8: width of the transferred-word counter.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- Req0_Valid  input  1  requester 0 has a word.
- Req0_Data  input  16  requester 0 word; routed externally to mux input IO.
- Req0_Ready  output  1  requester 0 word accepted this cycle.
- Req1_Valid  input  1  requester 1 has a word.
- Req1_Data  input  16  requester 1 word; routed externally to mux input I1.
- Req1_Ready  output  1  requester 1 word accepted this cycle.
- Mux_Sel  output  1  select to the external 16-bit mux: 1 passes IO (requester 0), 0 passes I1 (requester 1).
- Mux_Result  input  16  external mux output.
- Out_Valid  output  1  output register holds a word.
- Out_Data  output  16  registered word.
- Out_Ready  input  1  consumer takes the word when Out_Valid is high.
- Out_Src  output  1  source of the Out_Data word: 0 = requester 0, 1 = requester 1.
- Word_Count  output  CNT_W  number of words accepted, modulo 2^CNT_W.

## Operation
- Output stage states:
  - EMPTY: Out_Valid=0.
  - FULL: Out_Valid=1.
- Space condition: space = EMPTY, or (FULL and Out_Ready).
- Grant, computed combinationally:
  - One valid requester: that requester wins.
  - Both valid: the requester other than Last_Grant wins.
  - Neither valid: no grant.
- Mux_Sel is 1 when requester 0 is granted, 0 when requester 1 is granted, and 1 when there is no grant.
- ReqN_Ready = grantN AND space. At most one Ready is high in any cycle.
- Accept (some ReqN_Valid and ReqN_Ready high) at the clock edge:
  - Out_Data <= Mux_Result; Out_Src <= N; Last_Grant <= N; Word_Count increments (wraps 2^CNT_W-1 -> 0); state becomes FULL.
- FULL with Out_Ready and no accept: state becomes EMPTY. Out_Data holds its value.
- FULL with Out_Ready and accept on the same edge: stays FULL with the new word. Throughput is 1 word per cycle.
- FULL with Out_Ready low: hold everything. Both Ready outputs are 0.
- Out_Data, Out_Src and Word_Count change only on accept.
- Reset mid-transfer discards the held word. No partial handshake survives reset.

## Timing
- Reset values:
  - Out_Valid=0, Out_Data=16'h0000, Out_Src=0, Word_Count=0, Last_Grant=1 (requester 0 wins the first tie), state EMPTY.
  - With no request, Mux_Sel=1 and both Ready outputs are 0.
- Latency: a word accepted at edge N appears on Out_Data with Out_Valid=1 after edge N. Ready/Mux_Sel to capture is 0 cycles because the combinational path goes through the external mux.
- Requesters must hold Valid and Data stable until Ready. Valid may drop only after acceptance.
- Under continuous contention with Out_Ready=1, grants alternate 0,1,0,1; each requester gets 1 word every 2 cycles.
- Out_Ready is sampled only while Out_Valid=1.

## Configuration
- MUX16_ARB_RR_EN:
  - Defined: round-robin tie-break via Last_Grant as above.
  - Undefined: fixed priority. Requester 0 always wins ties, and requester 1 is served only when Req0_Valid=0. Last_Grant is not implemented; Out_Src still reports the source.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert RST mid-FULL with Out_Data=16'hBEEF -> Out_Valid=0, Out_Data=0, Word_Count=0 immediately (asynchronous), and Mux_Sel=1.
- Single requester: Req1_Valid=1, Req1_Data=16'h1234, Out_Ready=1 -> Mux_Sel=0, Req1_Ready=1, and the next cycle shows Out_Data=16'h1234, Out_Src=1, Word_Count=1.
- Contention: both Valid held high for 4 cycles, data 16'hAAAA/16'h5555, Out_Ready=1 -> outputs AAAA,5555,AAAA,5555 with Out_Src 0,1,0,1. With MUX16_ARB_RR_EN undefined -> AAAA on all four cycles.
- Backpressure: FULL with Out_Ready=0 for 3 cycles and both Valid high -> both Ready=0 and Out_Data stable; on Out_Ready=1, same-edge replacement keeps Out_Valid=1.
- Counter wrap: CNT_W=8, 256 accepts -> Word_Count returns to 0 and the 257th accept gives 1.
- Drain: one accept then Out_Ready=1 with no Valid -> Out_Valid falls after 1 cycle and Out_Data is retained.
